user_input_port: RTL and testbench

//   User-side end of the processor input handshake. When the core stalls on an input

---
 rtl/io_pkg.sv | 16 +
 rtl/user_input_port_if.sv | 14 +
 rtl/key_debounce.sv | 48 ++++
 rtl/user_input_port.sv | 103 ++++++++++
 tb/tb_user_input_port.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/io_pkg.sv
// Shared definitions for the user input handshake: FSM state encoding and
// default sizing constants.
package io_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    ACK     = 2'd2,
    RELEASE = 2'd3
  } port_state_t;

  localparam int DEFAULT_SW_WIDTH        = 18;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;
  localparam int WORD_WIDTH              = 32;

endpackage

// File: rtl/user_input_port_if.sv
// Core-side handshake bundle: the core raises input_flag and receives the
// captured word with a one-cycle input_ready strobe.
interface user_input_port_if;
  import io_pkg::*;

  logic                  input_flag;
  logic [WORD_WIDTH-1:0] user_input;
  logic                  input_ready;
  logic                  waiting;

  modport master (output input_flag, input user_input, input input_ready, input waiting);
  modport slave  (input input_flag, output user_input, output input_ready, output waiting);

endinterface

// File: rtl/key_debounce.sv
// Active-low pushbutton conditioner: 2-flop synchronizer, stability counter and
// a one-cycle strobe on each debounced released->pressed transition.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = io_pkg::DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic CLK,
  input  logic reset,
  input  logic key_n,
  output logic pressed,
  output logic press_evt
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          level_reg;   // debounced raw level, 1 = released
  logic [CW-1:0] cnt_reg;
  logic          evt_reg;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      level_reg <= 1'b1;
      cnt_reg   <= '0;
      evt_reg   <= 1'b0;
    end else begin
      sync1_reg <= key_n;
      sync2_reg <= sync1_reg;
      evt_reg   <= 1'b0;
      if (sync2_reg == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CW'(DEBOUNCE_CYCLES)) begin
        // Counter never passes DEBOUNCE_CYCLES: the flip clears it.
        level_reg <= sync2_reg;
        cnt_reg   <= '0;
        evt_reg   <= ~sync2_reg;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

  assign pressed   = ~level_reg;
  assign press_evt = evt_reg;

endmodule

// File: rtl/user_input_port.sv
// Waits for a debounced key press while the core is stalled on an input
// instruction, captures and widens SW, and strobes input_ready for one cycle.
module user_input_port
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SW_WIDTH        = DEFAULT_SW_WIDTH,
  parameter bit SIGN_EXTEND     = 1'b1
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic                insert,
  input  logic [SW_WIDTH-1:0] SW,
  user_input_port_if.slave    bus
);

  logic                  key_pressed;
  logic                  press_evt;
  logic [WORD_WIDTH-1:0] sw_ext;

  port_state_t           state_reg;
  logic [WORD_WIDTH-1:0] user_input_reg;
  logic                  ready_reg;
  logic                  waiting_reg;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .CLK      (CLK),
    .reset    (reset),
    .key_n    (insert),
    .pressed  (key_pressed),
    .press_evt(press_evt)
  );

  generate
    if (SW_WIDTH >= WORD_WIDTH) begin : g_trunc
      assign sw_ext = SW[WORD_WIDTH-1:0];
    end else if (SIGN_EXTEND) begin : g_sext
      assign sw_ext = {{(WORD_WIDTH-SW_WIDTH){SW[SW_WIDTH-1]}}, SW};
    end else begin : g_zext
      assign sw_ext = {{(WORD_WIDTH-SW_WIDTH){1'b0}}, SW};
    end
  endgenerate

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      user_input_reg <= '0;
      ready_reg      <= 1'b0;
      waiting_reg    <= 1'b0;
    end else begin
      ready_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.input_flag) begin
            if (key_pressed) begin
              state_reg <= RELEASE;
            end else begin
              state_reg   <= ARMED;
              waiting_reg <= 1'b1;
            end
          end
        end
        RELEASE: begin
          // A key still down from an earlier press must be let go first.
          if (!key_pressed) begin
            if (bus.input_flag) begin
              state_reg   <= ARMED;
              waiting_reg <= 1'b1;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        ARMED: begin
          // A dropped request wins over a coincident press.
          if (!bus.input_flag) begin
            state_reg   <= IDLE;
            waiting_reg <= 1'b0;
          end else if (press_evt) begin
            state_reg      <= ACK;
            user_input_reg <= sw_ext;
            ready_reg      <= 1'b1;
            waiting_reg    <= 1'b0;
          end
        end
        ACK: begin
          state_reg <= key_pressed ? RELEASE : IDLE;
        end
        default: begin
          state_reg   <= IDLE;
          waiting_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.user_input  = user_input_reg;
  assign bus.input_ready = ready_reg;
  assign bus.waiting     = waiting_reg;

endmodule

// File: tb/tb_user_input_port.sv
// Scoreboard bench for user_input_port: two instances (sign- and zero-extend)
// share stimulus; each ready pulse is checked against a queue of expected words.
module tb_user_input_port;
  import io_pkg::*;

  localparam int D  = 4;
  localparam int SW = 18;

  logic          CLK = 1'b0;
  logic          reset;
  logic          insert;
  logic          flag;
  logic [SW-1:0] sw;

  int total = 0;
  int bad   = 0;
  logic [31:0] q_a[$];
  logic [31:0] q_b[$];

  user_input_port_if if_a ();
  user_input_port_if if_b ();
  assign if_a.input_flag = flag;
  assign if_b.input_flag = flag;

  user_input_port #(.DEBOUNCE_CYCLES(D), .SW_WIDTH(SW), .SIGN_EXTEND(1'b1)) dut_a (
    .CLK(CLK), .reset(reset), .insert(insert), .SW(sw), .bus(if_a.slave));
  user_input_port #(.DEBOUNCE_CYCLES(D), .SW_WIDTH(SW), .SIGN_EXTEND(1'b0)) dut_b (
    .CLK(CLK), .reset(reset), .insert(insert), .SW(sw), .bus(if_b.slave));

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [31:0] ea, input logic [31:0] eb);
    q_a.push_back(ea);
    q_b.push_back(eb);
  endtask

  // Monitors: every ready pulse must match the oldest expectation.
  always @(negedge CLK) begin
    if (if_a.input_ready === 1'b1) begin
      total++;
      if (q_a.size() == 0) begin
        bad++;
        $display("FAIL pulse_a: unexpected pulse, user_input=%h", if_a.user_input);
      end else begin
        logic [31:0] e;
        e = q_a.pop_front();
        if (if_a.user_input !== e) begin
          bad++;
          $display("FAIL word_a: got %h expected %h", if_a.user_input, e);
        end else $display("ok   word_a: %h", if_a.user_input);
      end
    end
  end

  always @(negedge CLK) begin
    if (if_b.input_ready === 1'b1) begin
      total++;
      if (q_b.size() == 0) begin
        bad++;
        $display("FAIL pulse_b: unexpected pulse, user_input=%h", if_b.user_input);
      end else begin
        logic [31:0] e;
        e = q_b.pop_front();
        if (if_b.user_input !== e) begin
          bad++;
          $display("FAIL word_b: got %h expected %h", if_b.user_input, e);
        end else $display("ok   word_b: %h", if_b.user_input);
      end
    end
  end

  initial begin
    int n;
    reset  = 1'b1;
    insert = 1'b1;
    flag   = 1'b0;
    sw     = '0;
    tick(2);
    check("reset_user_input", if_a.user_input, 32'h0);
    check("reset_ready", {31'b0, if_a.input_ready}, 32'h0);
    check("reset_waiting", {31'b0, if_a.waiting}, 32'h0);
    reset = 1'b0;
    tick(2);

    // 1. basic capture and latency
    sw = 18'h00005; flag = 1'b1;
    tick(2);
    check("armed_waiting", {31'b0, if_a.waiting}, 32'h1);
    push(32'h00000005, 32'h00000005);
    insert = 1'b0;
    n = 0;
    do begin tick(1); n++; end while (if_a.input_ready !== 1'b1 && n < 20);
    check("latency", n, 8);
    tick(1);
    flag = 1'b0;
    insert = 1'b1;
    tick(12);
    check("hold_user_input", if_a.user_input, 32'h00000005);

    // 2. sign / zero extension
    sw = 18'h20001; flag = 1'b1;
    tick(2);
    push(32'hFFFE0001, 32'h00020001);
    insert = 1'b0;
    tick(12);
    flag = 1'b0; insert = 1'b1;
    tick(12);

    // 3. bounce shorter than the debounce window
    flag = 1'b1;
    tick(2);
    sw = 18'h3FFFF;
    for (int i = 0; i < 10; i++) begin
      insert = ~insert;
      tick(2);
    end
    tick(12);
    check("bounce_state", 32'(dut_a.state_reg), 32'(ARMED));
    check("bounce_waiting", {31'b0, if_a.waiting}, 32'h1);
    check("bounce_user_input", if_a.user_input, 32'hFFFE0001);
    flag = 1'b0;
    tick(2);

    // 4. key held before the request
    insert = 1'b0;
    tick(12);
    sw = 18'h00123; flag = 1'b1;
    tick(2);
    check("held_state", 32'(dut_a.state_reg), 32'(RELEASE));
    check("held_waiting", {31'b0, if_a.waiting}, 32'h0);
    tick(10);
    insert = 1'b1;
    tick(12);
    check("released_state", 32'(dut_a.state_reg), 32'(ARMED));
    push(32'h00000123, 32'h00000123);
    insert = 1'b0;
    tick(12);
    tick(20);
    check("second_req_state", 32'(dut_a.state_reg), 32'(RELEASE));
    flag = 1'b0; insert = 1'b1;
    tick(12);
    check("idle_after_held", 32'(dut_a.state_reg), 32'(IDLE));

    // 5. request drops in the same cycle as the press event
    flag = 1'b1;
    tick(2);
    sw = 18'h00777;
    insert = 1'b0;
    tick(7);
    flag = 1'b0;
    check("evt_coincident", {31'b0, dut_a.u_debounce.press_evt}, 32'h1);
    tick(1);
    check("abort_state", 32'(dut_a.state_reg), 32'(IDLE));
    check("abort_ready", {31'b0, if_a.input_ready}, 32'h0);
    check("abort_user_input", if_a.user_input, 32'h00000123);
    tick(5);
    insert = 1'b1;
    tick(12);

    // 6. reset during the ready cycle
    flag = 1'b1;
    tick(2);
    sw = 18'h0ABCD;
    insert = 1'b0;
    n = 0;
    do begin tick(1); n++; end while (if_a.input_ready !== 1'b1 && n < 20);
    check("ack_seen", {31'b0, if_a.input_ready}, 32'h1);
    check("ack_word", if_a.user_input, 32'h0000ABCD);
    reset = 1'b1;
    #1;
    check("rst_ready", {31'b0, if_a.input_ready}, 32'h0);
    check("rst_user_input", if_a.user_input, 32'h0);
    check("rst_waiting", {31'b0, if_a.waiting}, 32'h0);
    insert = 1'b1; flag = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(1);
    check("rst_state", 32'(dut_a.state_reg), 32'(IDLE));
    check("rst_counter", 32'(dut_a.u_debounce.cnt_reg), 32'h0);
    tick(5);

    check("pending_a", q_a.size(), 0);
    check("pending_b", q_b.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
